// File: rtl/ct_hpcp_ovf_int_ctrl_pkg.sv
// Shared PMU definitions for the overflow interrupt controller:
// FSM state encoding and the default counter count.
package ct_hpcp_ovf_int_ctrl_pkg;

  localparam int NUM_CNT_DEF = 32;

  // 2'b11 is unused and is steered back to IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_CLR = 2'b10
  } ovf_state_e;

endpackage

// File: rtl/ct_hpcp_ovf_int_ctrl_if.sv
// Bus between the PMU (master side) and the overflow interrupt controller
// (slave side): overflow pulses, CSR access and the interrupt handshake.
interface ct_hpcp_ovf_int_ctrl_if #(
  parameter int NUM_CNT = ct_hpcp_ovf_int_ctrl_pkg::NUM_CNT_DEF
);

  logic [NUM_CNT-1:0] cntinten;
  logic [NUM_CNT-1:0] cnt_ovf_pulse;
  logic               ovf_wen;
  logic [NUM_CNT-1:0] hpcp_wdata;
  logic               ovf_rd_req;
  logic [NUM_CNT-1:0] ovf_rdata;
  logic               ovf_rd_vld;
  logic               hpcp_int_req;
  logic               hpcp_int_ack;

  modport master (
    output cntinten, cnt_ovf_pulse, ovf_wen, hpcp_wdata, ovf_rd_req, hpcp_int_ack,
    input  ovf_rdata, ovf_rd_vld, hpcp_int_req
  );

  modport slave (
    input  cntinten, cnt_ovf_pulse, ovf_wen, hpcp_wdata, ovf_rd_req, hpcp_int_ack,
    output ovf_rdata, ovf_rd_vld, hpcp_int_req
  );

endinterface

// File: rtl/ct_hpcp_ovf_int_ctrl_reg.sv
// One overflow status bit: software write with the hardware overflow set
// taking priority when both land in the same cycle.
module ct_hpcp_ovf_reg (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic wen_i,
  input  logic wdata_i,
  input  logic set_i,
  output logic q_o
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = (wen_i ? wdata_i : q_q) | set_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ct_hpcp_ovf_int_ctrl.sv
// Overflow status register, enable masking and a one-request-per-episode
// interrupt handshake towards the core interrupt logic.
module ct_hpcp_ovf_int_ctrl
  import ct_hpcp_ovf_int_ctrl_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF
) (
  input  logic                    hpcp_clk,
  input  logic                    cpurst_b,
  ct_hpcp_ovf_int_ctrl_if.slave   bus
);

  logic [NUM_CNT-1:0] status_q;
  logic [NUM_CNT-1:0] rdata_q;
  logic [NUM_CNT-1:0] rdata_d;
  logic               rd_vld_q;
  logic               int_req_q;
  logic               int_req_d;
  logic               pending;
  ovf_state_e         state_q;
  ovf_state_e         state_d;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_status
    ct_hpcp_ovf_reg u_bit (
      .clk_i   (hpcp_clk),
      .rst_n_i (cpurst_b),
      .wen_i   (bus.ovf_wen),
      .wdata_i (bus.hpcp_wdata[i]),
      .set_i   (bus.cnt_ovf_pulse[i]),
      .q_o     (status_q[i])
    );
  end

  // Enable bits only mask the request; status bits stay set regardless.
  assign pending = |(status_q & bus.cntinten);

  always_comb begin
    rdata_d = bus.ovf_rd_req ? status_q : rdata_q;
  end

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rd_vld_q <= bus.ovf_rd_req;
    end
  end

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_req_q <= int_req_d;
    end
  end

  // After an ack, wait for pending to drain before a new episode may start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending) state_d = REQ;
      end
      REQ: begin
        if (bus.hpcp_int_ack) state_d = WAIT_CLR;
        else if (!pending)    state_d = IDLE;
      end
      WAIT_CLR: begin
        if (!pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req_d = (state_d == REQ);
  end

  assign bus.ovf_rdata    = rdata_q;
  assign bus.ovf_rd_vld   = rd_vld_q;
  assign bus.hpcp_int_req = int_req_q;

endmodule
